// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard unit.
// Forwarding-mux select codes, register index width and per-stage destination info.
package fwd_hazard_unit_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wr;
    } dst_info_t;

    // x0 is hard-wired zero, so a write to it never produces a hazard.
    function automatic logic stage_writes(input dst_info_t dst, input logic [REG_AW-1:0] r);
        return dst.valid && dst.wr && (dst.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// fwd_match: combinational "stage writes register r" comparator, one per stage/source pair.
module fwd_match
    import fwd_hazard_unit_pkg::*;
(
    input  dst_info_t         dst,
    input  logic [REG_AW-1:0] r,
    output logic              hit
);

    assign hit = stage_writes(dst, r);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generator with an internal EX/MEM/WB shadow pipeline.
// Optional feature macro: FORWARDING_EN (undefined: no forwarding, stall until the writer retires).
module fwd_hazard_unit #(
    parameter int REG_AW = fwd_hazard_unit_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall
);

    import fwd_hazard_unit_pkg::*;

    logic [1:0][REG_AW-1:0] id_src;
    logic [1:0]             id_use;

    assign id_src = {id_rs2, id_rs1};
    assign id_use = {id_use_rs2, id_use_rs1};

    dst_info_t ex_dst_reg;
    dst_info_t mem_dst_reg;
    dst_info_t wb_dst_reg;

`ifdef FORWARDING_EN
    logic [1:0][REG_AW-1:0] ex_src_reg;
    logic [1:0]             ex_use_reg;
    logic                   ex_mrd_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_dst_reg  <= '0;
            mem_dst_reg <= '0;
            wb_dst_reg  <= '0;
`ifdef FORWARDING_EN
            ex_src_reg  <= '0;
            ex_use_reg  <= '0;
            ex_mrd_reg  <= 1'b0;
`endif
        end else begin
            wb_dst_reg       <= mem_dst_reg;
            mem_dst_reg      <= ex_dst_reg;
            // A stalled or flushed ID instruction must not reach EX: insert a bubble.
            ex_dst_reg.valid <= id_valid && !stall && !flush;
            ex_dst_reg.rd    <= id_rd;
            ex_dst_reg.wr    <= id_reg_write;
`ifdef FORWARDING_EN
            ex_src_reg       <= id_src;
            ex_use_reg       <= id_use;
            ex_mrd_reg       <= id_mem_read;
`endif
        end
    end

`ifdef FORWARDING_EN
    dst_info_t        fwd_dst [2];
    logic [3:0]       ex_hit;
    logic [1:0][1:0]  sel;
    dst_info_t        load_dst;
    logic [1:0]       load_hit;

    assign fwd_dst[0] = mem_dst_reg;
    assign fwd_dst[1] = wb_dst_reg;

    // ex_hit[2*stage + source], stage 0 = MEM, 1 = WB.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd_stage
        for (genvar gj = 0; gj < 2; gj++) begin : g_fwd_src
            fwd_match u_match (
                .dst (fwd_dst[gi]),
                .r   (ex_src_reg[gj]),
                .hit (ex_hit[2*gi+gj])
            );
        end
    end

    for (genvar gj = 0; gj < 2; gj++) begin : g_sel
        always_comb begin
            sel[gj] = FWD_RF;
            if (ex_dst_reg.valid && ex_use_reg[gj]) begin
                if (ex_hit[gj])
                    sel[gj] = FWD_MEM;
                else if (ex_hit[2+gj])
                    sel[gj] = FWD_WB;
            end
        end
    end

    assign fwd_a_sel = sel[0];
    assign fwd_b_sel = sel[1];

    // Only a load in EX cannot be forwarded in time; its rd counts regardless of wr.
    assign load_dst.valid = ex_dst_reg.valid && ex_mrd_reg;
    assign load_dst.rd    = ex_dst_reg.rd;
    assign load_dst.wr    = 1'b1;

    for (genvar gj = 0; gj < 2; gj++) begin : g_load_use
        fwd_match u_match (
            .dst (load_dst),
            .r   (id_src[gj]),
            .hit (load_hit[gj])
        );
    end

    assign stall = id_valid && !flush && |(load_hit & id_use);
`else
    dst_info_t  stage_dst [3];
    logic [5:0] id_hit;
    logic [5:0] id_need;

    assign stage_dst[0] = ex_dst_reg;
    assign stage_dst[1] = mem_dst_reg;
    assign stage_dst[2] = wb_dst_reg;

    // Without forwarding every in-flight writer blocks a dependent reader until it retires.
    for (genvar gi = 0; gi < 3; gi++) begin : g_stage
        for (genvar gj = 0; gj < 2; gj++) begin : g_src
            fwd_match u_match (
                .dst (stage_dst[gi]),
                .r   (id_src[gj]),
                .hit (id_hit[2*gi+gj])
            );
            assign id_need[2*gi+gj] = id_hit[2*gi+gj] && id_use[gj];
        end
    end

    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
    assign stall     = id_valid && !flush && |id_need;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit; covers both FORWARDING_EN builds with hand-computed vectors.
`timescale 1ns/1ps
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, flush;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall;

    int checks = 0;
    int errors = 0;

    fwd_hazard_unit #(.REG_AW(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One cycle: drive ID, let it settle, compare outputs, then advance past the edge.
    task automatic cyc(input string tag, input logic v,
                       input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd, input logic wr, input logic mrd, input logic fl,
                       input logic [1:0] ea, input logic [1:0] eb, input logic es);
        id_valid     = v;
        id_rs1       = r1;
        id_use_rs1   = u1;
        id_rs2       = r2;
        id_use_rs2   = u2;
        id_rd        = rd;
        id_reg_write = wr;
        id_mem_read  = mrd;
        flush        = fl;
        #1;
        $display("cycle %-6s a=%0d b=%0d stall=%0d", tag, fwd_a_sel, fwd_b_sel, stall);
        check({tag, ".a"},     8'(fwd_a_sel), 8'(ea));
        check({tag, ".b"},     8'(fwd_b_sel), 8'(eb));
        check({tag, ".stall"}, 8'(stall),     8'(es));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++)
            cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle("rst", 3);

`ifdef FORWARDING_EN
        // add x5,x1,x2 ; add x6,x5,x5
        cyc("fw_w",  1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0);
        cyc("fw_r",  1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0);
        cyc("fw_ex", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        idle("fw_dr", 3);
        // lw x7 ; add x8,x7,x1 -> one bubble, then WB forward on A
        cyc("lu_ld", 1, 3, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0);
        cyc("lu_st", 1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 0, 1);
        cyc("lu_hd", 1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 0, 0);
        cyc("lu_ex", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        idle("lu_dr", 3);
        // lw x9 ; add x9 ; reader of x9 -> MEM beats WB
        cyc("pr_ld", 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0);
        cyc("pr_ad", 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        cyc("pr_rd", 1, 9, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0);
        cyc("pr_ex", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle("pr_dr", 3);
        // lw x0 ; reader of x0
        cyc("x0_ld", 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc("x0_rd", 1, 0, 1, 0, 1, 11, 1, 0, 0, 0, 0, 0);
        cyc("x0_ex", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("x0_dr", 3);
        // lw x12 ; dependent reader flushed in the hazard cycle
        cyc("fl_ld", 1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 0);
        cyc("fl_hz", 1, 12, 1, 12, 1, 13, 1, 0, 1, 0, 0, 0);
        cyc("fl_bb", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("fl_dr", 3);
        reset = 1'b1;
        cyc("rs_w",  1, 0, 0, 0, 0, 14, 1, 1, 0, 0, 0, 0);
`else
        // add x5 ; reader of x5 -> stall while EX, MEM, WB hold the writer
        cyc("nf_w",   1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0);
        cyc("nf_ex",  1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 1);
        cyc("nf_mem", 1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 1);
        cyc("nf_wb",  1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 1);
        cyc("nf_go",  1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0);
        idle("nf_dr", 3);
        // writer of x0 ; reader of x0
        cyc("x0_w",  1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc("x0_r",  1, 0, 1, 0, 1, 3, 1, 0, 0, 0, 0, 0);
        idle("x0_dr", 3);
        // lw x7 ; add x12<-x7 flushed ; reader of x12 sees no writer
        cyc("fl_ld", 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0);
        cyc("fl_hz", 1, 7, 1, 0, 0, 12, 1, 0, 1, 0, 0, 0);
        cyc("fl_bb", 1, 12, 1, 0, 0, 14, 1, 0, 0, 0, 0, 0);
        idle("fl_dr", 3);
        // use flags and id_valid gate the stall; rs2 path on its own
        cyc("uo_w",  1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, 0);
        cyc("uo_u",  1, 13, 0, 13, 0, 15, 1, 0, 0, 0, 0, 0);
        cyc("uo_v",  0, 13, 1, 13, 1, 15, 1, 0, 0, 0, 0, 0);
        cyc("uo_y",  1, 0, 0, 13, 1, 15, 1, 0, 0, 0, 0, 1);
        idle("uo_dr", 3);
        reset = 1'b1;
        cyc("rs_w",  1, 0, 0, 0, 0, 14, 1, 1, 0, 0, 0, 0);
`endif
        // A writer presented while reset is high must be dropped.
        reset = 1'b0;
        cyc("rs_r",  1, 14, 1, 14, 1, 16, 1, 0, 0, 0, 0, 0);
        cyc("rs_x",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Generates the select codes for the EX-stage operand forwarding muxes and the load-use stall of the 5-stage RISC-V pipeline. It tracks the destination-register state of EX, MEM and WB internally in its own shadow pipeline, fed from decode. Per cycle it drives one 2-bit select per ALU operand (0 = register file, 1 = EX/MEM result, 2 = MEM/WB result) into the existing 3-to-1 operand muxes, plus a stall to the PC and IF/ID registers.

## Interface
Parameters:
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  source indices of the ID instruction.
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2.
- id_rd  in  REG_AW  destination index.
- id_reg_write  in  1  ID instruction writes rd.
- id_mem_read  in  1  ID instruction is a load.
- flush  in  1  taken branch/jump resolved in EX; kill ID and EX.
- fwd_a_sel  out  2  select for operand-A mux.
- fwd_b_sel  out  2  select for operand-B mux.
- stall  out  1  hold PC and IF/ID; bubble into EX.

## Operation
- Shadow registers: EX {valid, rs1, rs2, use1, use2, rd, wr, mrd}; MEM {valid, rd, wr}; WB {valid, rd, wr}.
- Each cycle: WB <= MEM, MEM <= EX. EX <= ID fields, unless stall or flush, in which case EX.valid <= 0.
- A stage "writes r" iff valid && wr && rd == r && r != 0. x0 is never forwarded and never stalls.
- fwd_a_sel, from the EX registers:
  - 1 if EX.use1 and MEM writes EX.rs1;
  - else 2 if EX.use1 and WB writes EX.rs1;
  - else 0.
  - MEM has priority over WB.
- fwd_b_sel: same rule with rs2/use2.
- Code 3 is never driven. With EX.valid = 0 both selects are 0.
- Load-use stall: EX.valid && EX.mrd && EX.rd != 0 && ID uses a source equal to EX.rd && id_valid.
- flush forces stall = 0. It also bubbles EX, since the ID instruction is discarded upstream.
- stall and flush in the same cycle: flush wins.

## Timing
- Reset: all valid bits 0, so fwd_a_sel = fwd_b_sel = 2'd0 and stall = 0 from the first cycle after reset.
- Selects and stall are combinational from registered state plus the ID inputs, and are valid in the same cycle.
- No handshake.
- Load-use costs exactly one bubble. The cycle after a stall, the load is in MEM, there is no longer a hazard, and the dependent instruction enters EX with select 2 one cycle later.
- A flush in cycle n gives EX.valid = 0 in n+1. MEM/WB still retire the instruction that was in EX in cycle n.
- Reset asserted mid-operation clears all stages in one cycle; in-flight hazards are dropped.

## Configuration
- FORWARDING_EN defined:
  - behaviour as above.
- FORWARDING_EN undefined:
  - fwd_a_sel = fwd_b_sel = 0 always.
  - stall asserts whenever a used ID source is written by EX, MEM or WB (register file is not write-through).
  - flush still overrides stall.

## Structure
- Shared pipeline package holds:
  - FWD_RF = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2;
  - REG_AW;
  - the per-stage destination-info struct.
- One sub-module: fwd_match. It is a combinational "stage writes r" comparator and is instantiated for each stage/source pair.

## Test plan
- Reset held 3 cycles, then released with id_valid = 0 -> stall = 0, both selects 0 throughout.
- add x5 then add x6,x5,x5 back to back (FORWARDING_EN) -> when the second is in EX: fwd_a_sel = fwd_b_sel = 1, stall never asserts.
- lw x7 followed by add x8,x7,x1 -> stall = 1 for exactly one cycle, then the add in EX has fwd_a_sel = 2 and fwd_b_sel = 0.
- add x9 in MEM and lw x9 in WB, EX reads x9 -> fwd_a_sel = 1 (MEM priority).
- Writer with rd = x0 followed by a reader of x0 -> selects 0, no stall.
- Load-use hazard with flush = 1 in the same cycle -> stall = 0, EX.valid = 0 next cycle.
- FORWARDING_EN undefined, add x5 then a reader of x5 -> stall held 3 cycles, selects always 0.
